memory_stage: RTL and testbench

//  Memory (MEM) stage of the 5-stage RISC-V pipeline. Consumes execute_memory_if results.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 34 +++
 rtl/memory_stage.sv | 172 +++++++++++++++++
 tb/tb_memory_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and constants
// Purpose: opcode and funct3 encodings, MEM stage FSM states and the
//          MEM-to-WB payload record.
// Ports:   none (package).
package riscv_pkg;

    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        reg_write;
    } mem_wb_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load data lane select and sign/zero extension
// Purpose: picks the addressed byte/half out of a fetched word and extends it.
// Ports:   rdata  - word returned by data memory
//          lane   - effective address bits [1:0]
//          funct3 - load size/sign encoding
//          value  - extended result for writeback
module lsu_load_align
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] rdata,
    input  logic [1:0]   lane,
    input  logic [2:0]   funct3,
    output logic [N-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        value    = rdata;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V MEM stage with req/gnt/rvalid data port
// Purpose: executes loads/stores, passes ALU results through, and holds a
//          registered payload for writeback with upstream backpressure.
// Ports:   clk, rst_n                   - clock, synchronous active-low reset
//          em_*                         - execute result input handshake/payload
//          dmem_req/we/be/addr/wdata    - data memory request (held until gnt)
//          dmem_gnt/rvalid/rdata        - data memory accept / load response
//          mw_valid/ready/rd/result/reg_write - writeback payload handshake
//          mem_fault                    - one-cycle misaligned/illegal pulse
module memory_stage
    import riscv_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              em_valid,
    output logic              em_ready,
    input  logic [6:0]        em_opcode,
    input  logic [2:0]        em_funct3,
    input  logic [4:0]        em_rd,
    input  logic [N-1:0]      em_alu_result,
    input  logic [N-1:0]      em_rs2_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [N-1:0]      dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [N-1:0]      dmem_rdata,
    output logic              mw_valid,
    input  logic              mw_ready,
    output logic [4:0]        mw_rd,
    output logic [N-1:0]      mw_result,
    output logic              mw_reg_write,
    output logic              mem_fault
);

    mem_state_t state, state_next;
    mem_wb_t    mw_q;

    logic       accept;
    logic       is_load, is_store, is_alu;
    logic       illegal_f3, misaligned;
    logic       mem_ok, mem_bad;
    logic [3:0] be_next;
    logic [N-1:0] wdata_next;
    logic [2:0] funct3_q;
    logic [1:0] lane_q;
    logic [4:0] rd_q;
    logic [N-1:0] load_value;

    assign em_ready = (state == IDLE) && (!mw_valid || mw_ready);
    assign accept   = em_valid && em_ready;
    assign dmem_req = (state == REQ);

    always_comb begin
        is_load  = (em_opcode == OPCODE_LOAD);
        is_store = (em_opcode == OPCODE_STORE);
        is_alu   = (em_opcode == OPCODE_REG_IMM) || (em_opcode == OPCODE_REG_REG) ||
                   (em_opcode == OPCODE_LUI)     || (em_opcode == OPCODE_AUIPC)   ||
                   (em_opcode == OPCODE_JAL)     || (em_opcode == OPCODE_JALR);

        illegal_f3 = 1'b0;
        if (is_load)
            illegal_f3 = (em_funct3 == 3'd3) || (em_funct3 == 3'd6) || (em_funct3 == 3'd7);
        else if (is_store)
            illegal_f3 = (em_funct3 > 3'd2);

        // funct3[1:0] encodes size for both loads and stores: 0=B, 1=H, 2=W
        misaligned = 1'b0;
        case (em_funct3[1:0])
            2'd1:    misaligned = em_alu_result[0];
            2'd2:    misaligned = (em_alu_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        mem_ok  = (is_load || is_store) && !illegal_f3 && !misaligned;
        mem_bad = (is_load || is_store) && (illegal_f3 || misaligned);

        be_next    = 4'b1111;
        wdata_next = em_rs2_data;
        case (em_funct3[1:0])
            2'd0: begin
                be_next    = 4'b0001 << em_alu_result[1:0];
                wdata_next = {4{em_rs2_data[7:0]}};
            end
            2'd1: begin
                be_next    = em_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{em_rs2_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = em_rs2_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && mem_ok) state_next = REQ;
            REQ:     if (dmem_gnt) state_next = dmem_we ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    lsu_load_align #(.N(N)) u_align (
        .rdata  (dmem_rdata),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_we   <= 1'b0;
            dmem_be   <= 4'd0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            funct3_q  <= 3'd0;
            lane_q    <= 2'd0;
            rd_q      <= 5'd0;
            mw_valid  <= 1'b0;
            mw_q      <= '0;
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= accept && mem_bad;

            if (accept && mem_ok) begin
                dmem_we    <= is_store;
                dmem_be    <= be_next;
                dmem_addr  <= {em_alu_result[ADDR_W-1:2], 2'b00};
                dmem_wdata <= wdata_next;
                funct3_q   <= em_funct3;
                lane_q     <= em_alu_result[1:0];
                rd_q       <= em_rd;
            end

            // The FSM only leaves IDLE with mw empty, so a load response
            // can always be captured without checking mw_ready.
            if (accept && is_alu) begin
                mw_valid       <= 1'b1;
                mw_q.rd        <= em_rd;
                mw_q.result    <= em_alu_result;
                mw_q.reg_write <= (em_rd != 5'd0);
            end else if ((state == WAIT) && dmem_rvalid) begin
                mw_valid       <= 1'b1;
                mw_q.rd        <= rd_q;
                mw_q.result    <= load_value;
                mw_q.reg_write <= (rd_q != 5'd0);
            end else if (mw_ready) begin
                mw_valid <= 1'b0;
            end
        end
    end

    assign mw_rd        = mw_q.rd;
    assign mw_result    = mw_q.result;
    assign mw_reg_write = mw_q.reg_write;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        em_valid;
    logic        em_ready;
    logic [6:0]  em_opcode;
    logic [2:0]  em_funct3;
    logic [4:0]  em_rd;
    logic [31:0] em_alu_result;
    logic [31:0] em_rs2_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mw_valid;
    logic        mw_ready;
    logic [4:0]  mw_rd;
    logic [31:0] mw_result;
    logic        mw_reg_write;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    always #5 clk = ~clk;

    memory_stage #(.N(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .em_valid      (em_valid),
        .em_ready      (em_ready),
        .em_opcode     (em_opcode),
        .em_funct3     (em_funct3),
        .em_rd         (em_rd),
        .em_alu_result (em_alu_result),
        .em_rs2_data   (em_rs2_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .mw_valid      (mw_valid),
        .mw_ready      (mw_ready),
        .mw_rd         (mw_rd),
        .mw_result     (mw_result),
        .mw_reg_write  (mw_reg_write),
        .mem_fault     (mem_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_em(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] rs2);
        em_valid      = 1'b1;
        em_opcode     = op;
        em_funct3     = f3;
        em_rd         = rd;
        em_alu_result = alu;
        em_rs2_data   = rs2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; em_valid = 1'b0; em_opcode = 7'd0; em_funct3 = 3'd0; em_rd = 5'd0;
        em_alu_result = 32'd0; em_rs2_data = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0; mw_ready = 1'b1;
        step(); step();
        checks++;
        if ({dmem_req, dmem_we, dmem_be, mw_valid, mw_rd, mw_reg_write, mem_fault} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {dmem_req, dmem_we, dmem_be, mw_valid, mw_rd, mw_reg_write, mem_fault});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, mw_result} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {dmem_addr, dmem_wdata, mw_result});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (em_ready !== 1'b1) begin errors++; $display("FAIL reset_em_ready got %b want 1", em_ready); end
    endtask

    task automatic test_alu();
        drive_em(OP_REG, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
        step();
        em_valid = 1'b0;
        checks++;
        if (mw_valid !== 1'b1 || mw_result !== 32'h0000_1234 || mw_rd !== 5'd5 || mw_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb got v=%b r=%h rd=%0d we=%b want v=1 r=00001234 rd=5 we=1", mw_valid, mw_result, mw_rd, mw_reg_write);
        end
        step();
        checks++;
        if (mw_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", mw_valid); end
        // rd==0: payload still valid but no register write
        drive_em(OP_IMM, 3'd0, 5'd0, 32'hCAFE_0001, 32'd0);
        step();
        em_valid = 1'b0;
        checks++;
        if (mw_valid !== 1'b1 || mw_reg_write !== 1'b0 || mw_result !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL alu_rd0 got v=%b we=%b r=%h want v=1 we=0 r=cafe0001", mw_valid, mw_reg_write, mw_result);
        end
        step();
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] ea,
                             input logic [31:0] rdata, input logic [31:0] exp);
        drive_em(OP_LOAD, f3, 5'd9, ea, 32'd0);
        step();
        em_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {ea[31:2], 2'b00} || em_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_req got req=%b we=%b addr=%h rdy=%b want req=1 we=0 addr=%h rdy=0", name, dmem_req, dmem_we, dmem_addr, em_ready, {ea[31:2], 2'b00});
        end
        step();
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL %s_req_hold got %b want 1", name, dmem_req); end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || mw_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait got req=%b v=%b want 0 0", name, dmem_req, mw_valid);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        checks++;
        if (mw_valid !== 1'b1 || mw_result !== exp || mw_rd !== 5'd9 || mw_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL %s_data got v=%b r=%h rd=%0d want v=1 r=%h rd=9", name, mw_valid, mw_result, mw_rd, exp);
        end
        step();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] ea,
                              input logic [31:0] rs2, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        drive_em(OP_STORE, f3, 5'd0, ea, rs2);
        step();
        em_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== exp_be || dmem_wdata !== exp_wd || dmem_addr !== {ea[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_req got req=%b we=%b be=%b wd=%h addr=%h want 1 1 %b %h %h", name, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, exp_be, exp_wd, {ea[31:2], 2'b00});
        end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        checks++;
        if (em_ready !== 1'b1 || dmem_req !== 1'b0 || mw_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got rdy=%b req=%b v=%b want 1 0 0", name, em_ready, dmem_req, mw_valid);
        end
        step();
    endtask

    task automatic test_fault(input string name, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ea);
        drive_em(op, f3, 5'd3, ea, 32'd0);
        step();
        em_valid = 1'b0;
        checks++;
        if (mem_fault !== 1'b1 || dmem_req !== 1'b0 || mw_valid !== 1'b0 || em_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_pulse got f=%b req=%b v=%b rdy=%b want 1 0 0 1", name, mem_fault, dmem_req, mw_valid, em_ready);
        end
        step();
        checks++;
        if (mem_fault !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_end got f=%b req=%b want 0 0", name, mem_fault, dmem_req);
        end
    endtask

    task automatic test_branch();
        drive_em(OP_BRANCH, 3'd0, 5'd4, 32'h0000_0040, 32'd0);
        step();
        em_valid = 1'b0;
        checks++;
        if (mw_valid !== 1'b0 || mem_fault !== 1'b0 || dmem_req !== 1'b0 || em_ready !== 1'b1) begin
            errors++;
            $display("FAIL branch got v=%b f=%b req=%b rdy=%b want 0 0 0 1", mw_valid, mem_fault, dmem_req, em_ready);
        end
        step();
    endtask

    task automatic test_backpressure();
        mw_ready = 1'b0;
        drive_em(OP_REG, 3'd0, 5'd12, 32'hA5A5_0F0F, 32'd0);
        step();
        drive_em(OP_REG, 3'd0, 5'd13, 32'h1111_2222, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mw_valid !== 1'b1 || mw_result !== 32'hA5A5_0F0F || mw_rd !== 5'd12 || em_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%h rd=%0d rdy=%b want 1 a5a50f0f 12 0", i, mw_valid, mw_result, mw_rd, em_ready);
            end
            step();
        end
        em_valid = 1'b0;
        mw_ready = 1'b1;
        #1;
        checks++;
        if (em_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", em_ready); end
        step();
        checks++;
        if (mw_valid !== 1'b0 || em_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got v=%b rdy=%b want 0 1", mw_valid, em_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        drive_em(OP_LOAD, 3'd2, 5'd7, 32'h0000_0300, 32'd0);
        step();
        em_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || em_ready !== 1'b0) begin
            errors++;
            $display("FAIL rw_inwait got req=%b rdy=%b want 0 0", dmem_req, em_ready);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        step();
        dmem_rvalid = 1'b0;
        checks++;
        if (mw_valid !== 1'b0 || em_ready !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rw_ignore got v=%b rdy=%b req=%b want 0 1 0", mw_valid, em_ready, dmem_req);
        end
        step();
        checks++;
        if (mw_valid !== 1'b0) begin errors++; $display("FAIL rw_after got %b want 0", mw_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load("lb",  3'd0, 32'h0000_0103, 32'h80FF_FF7F, 32'hFFFF_FF80);
        test_load("lbu", 3'd4, 32'h0000_0103, 32'h80FF_FF7F, 32'h0000_0080);
        test_load("lb0", 3'd0, 32'h0000_0100, 32'h80FF_FF7F, 32'h0000_007F);
        test_load("lh",  3'd1, 32'h0000_0102, 32'h80FF_FF7F, 32'hFFFF_80FF);
        test_load("lhu", 3'd5, 32'h0000_0102, 32'h80FF_FF7F, 32'h0000_80FF);
        test_load("lw",  3'd2, 32'h0000_0100, 32'h80FF_FF7F, 32'h80FF_FF7F);
        test_store("sh", 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb", 3'd0, 32'h0000_0002, 32'h1234_5678, 4'b0100, 32'h7878_7878);
        test_store("sw", 3'd2, 32'h0000_0404, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        test_fault("lw_mis", OP_LOAD, 3'd2, 32'h0000_0101);
        test_fault("lh_mis", OP_LOAD, 3'd1, 32'h0000_0103);
        test_fault("st_f3", OP_STORE, 3'd3, 32'h0000_0000);
        test_fault("ld_f3", OP_LOAD, 3'd6, 32'h0000_0000);
        test_branch();
        test_backpressure();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
